// File: rtl/burst_rd_responder_if.sv
// Requester-side and backing-memory-side signals of burst_rd_responder.
// The slave modport is the responder's view; master is the requester/memory side.
interface burst_rd_responder_if #(
  parameter int ADDR_W = 23
);
  logic [31:0]       address;
  logic              rw_req;
  logic [7:0]        burst_len;
  logic              data_available;
  logic [15:0]       read_data;
  logic              busy;
  logic              err_overlen;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ready;
  logic [15:0]       mem_rdata;
  logic              mem_rvalid;

  modport slave (
    input  address, rw_req, burst_len, mem_ready, mem_rdata, mem_rvalid,
    output data_available, read_data, busy, err_overlen, mem_addr, mem_rd
  );

  modport master (
    output address, rw_req, burst_len, mem_ready, mem_rdata, mem_rvalid,
    input  data_available, read_data, busy, err_overlen, mem_addr, mem_rd
  );
endinterface

// File: rtl/burst_rd_responder.sv
// Burst read responder: prefetches up to MAX_WORDS 16-bit words from a pipelined
// memory into a local buffer, announces them with a pulse, then streams them gap-free.
module burst_rd_responder #(
  parameter int ADDR_W    = 23,
  parameter int MAX_WORDS = 32
) (
  input logic                 clk,
  input logic                 reset,
  burst_rd_responder_if.slave bus
);
  localparam int IW = $clog2(MAX_WORDS);
  localparam int CW = IW + 1;
  localparam logic [31:0] MAX_LEN_M1 = 32'(MAX_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, FILL, ANNOUNCE, STREAM, WAIT_RELEASE, DRAIN
  } state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     len, issued, received, stream_cnt;
  logic [15:0]       buffer [MAX_WORDS];

  logic          clamp, capture, rd_req, issue, accept, drained;
  logic [CW-1:0] req_len;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{bus.address[31:ADDR_W+1], bus.address[0]};

  always_comb begin
    clamp   = 32'(bus.burst_len) > MAX_LEN_M1;
    req_len = clamp ? CW'(MAX_WORDS) : CW'(bus.burst_len) + CW'(1);
    capture = (state == IDLE) && bus.rw_req;
    rd_req  = (state == FILL) && bus.rw_req && (issued < len);
    issue   = rd_req && bus.mem_ready;
    // Beats beyond the issued count (e.g. stragglers after a reset) are dropped here.
    accept  = ((state == FILL) || (state == DRAIN)) && bus.mem_rvalid && (received < issued);
    drained = (received + CW'(accept)) == issued;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:         if (bus.rw_req) next_state = FILL;
      FILL:         if (!bus.rw_req) next_state = DRAIN;
                    else if (received == len) next_state = ANNOUNCE;
      ANNOUNCE:     next_state = bus.rw_req ? STREAM : IDLE;
      STREAM:       if (!bus.rw_req) next_state = IDLE;
                    else if (stream_cnt == len - CW'(1)) next_state = WAIT_RELEASE;
      WAIT_RELEASE: if (!bus.rw_req) next_state = IDLE;
      DRAIN:        if (drained) next_state = IDLE;
      default:      next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      base       <= '0;
      len        <= '0;
      issued     <= '0;
      received   <= '0;
      stream_cnt <= '0;
    end else begin
      if (capture) begin
        base     <= bus.address[ADDR_W:1];
        len      <= req_len;
        issued   <= '0;
        received <= '0;
      end else begin
        if (issue)  issued   <= issued + CW'(1);
        if (accept) received <= received + CW'(1);
      end
      stream_cnt <= (state == STREAM) ? stream_cnt + CW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && (state == FILL)) buffer[received[IW-1:0]] <= bus.mem_rdata;
  end

  always_comb begin
    bus.busy           = state != IDLE;
    bus.data_available = state == ANNOUNCE;
    bus.read_data      = (state == STREAM) ? buffer[stream_cnt[IW-1:0]] : '0;
    bus.err_overlen    = reset && capture && clamp;
    bus.mem_rd         = rd_req;
    bus.mem_addr       = rd_req ? base + ADDR_W'(issued) : '0;
  end
endmodule

// File: tb/tb_burst_rd_responder.sv
// Directed bench for burst_rd_responder: a table of burst requests against a
// pipelined memory model (mem[i] = i), plus abort/drain and mid-stream reset sequences.
module tb_burst_rd_responder;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  burst_rd_responder_if #(.ADDR_W(23)) bus ();

  burst_rd_responder #(.ADDR_W(23), .MAX_WORDS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] address;
    logic [7:0]  burst_len;
    bit          toggle;
    int unsigned lat;
    int unsigned words;
    logic [22:0] mem_base;
    logic [15:0] first;
    bit          err;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    int unsigned due;
  } beat_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned n_acc   = 0;
  int unsigned lat     = 1;
  bit          toggle  = 1'b0;
  beat_t       pend[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: accepts on mem_rd & mem_ready, returns mem[addr] = addr after lat cycles.
  initial begin
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'hDEAD;
    forever begin
      @(negedge clk);
      bus.mem_ready = toggle ? ~bus.mem_ready : 1'b1;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = pend[0].data;
        void'(pend.pop_front());
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'hDEAD;
      end
      #1;
      if (bus.mem_rd && bus.mem_ready) begin
        pend.push_back('{data: 16'(bus.mem_addr), due: cyc + lat});
        n_acc++;
      end
    end
  end

  task automatic run_burst(input vec_t v, input int abort_word);
    int          pulse_i = -1;
    int          k;
    int unsigned n_pulse = 0, n_stream = 0, n_err_extra = 0, n_nonzero = 0, n_idle = 0;
    int unsigned acc0, idx;
    logic [22:0] ea;
    logic [15:0] ew;
    lat    = v.lat;
    toggle = v.toggle;
    @(negedge clk);
    bus.address   = v.address;
    bus.burst_len = v.burst_len;
    bus.rw_req    = 1'b1;
    acc0          = n_acc;
    #2;
    check("capture_busy", {31'd0, bus.busy}, 32'd0);
    check("capture_err_overlen", {31'd0, bus.err_overlen}, {31'd0, v.err});
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.address   = 32'hA5A5_0000 ^ 32'(i);
      bus.burst_len = 8'(i * 7);
      #2;
      if (bus.mem_rd && bus.mem_ready) begin
        idx = n_acc - acc0 - 1;
        ea  = v.mem_base + 23'(idx);
        check("mem_addr", 32'(bus.mem_addr), 32'(ea));
      end
      if (bus.err_overlen) n_err_extra++;
      if (bus.data_available) begin
        n_pulse++;
        if (pulse_i < 0) pulse_i = i;
      end
      if (pulse_i >= 0 && i > pulse_i && i <= pulse_i + int'(v.words)) begin
        k  = i - pulse_i - 1;
        ew = v.first + 16'(k);
        n_stream++;
        check("stream_word", 32'(bus.read_data), 32'(ew));
        if (k == abort_word) return;
      end else if (bus.read_data != 16'd0) begin
        n_nonzero++;
      end
      if (pulse_i >= 0 && i == pulse_i + int'(v.words)) break;
    end
    check("data_available_pulses", n_pulse, 1);
    check("stream_len", n_stream, v.words);
    check("reads_issued", n_acc - acc0, v.words);
    check("err_overlen_outside_capture", n_err_extra, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      if (!bus.busy) n_idle++;
      if (bus.read_data != 16'd0 || bus.data_available) n_nonzero++;
    end
    check("busy_while_held", n_idle, 0);
    check("read_data_zero_outside_stream", n_nonzero, 0);
    @(negedge clk);
    bus.rw_req = 1'b0;
    #2;
    check("busy_in_release_cycle", {31'd0, bus.busy}, 32'd1);
  endtask

  initial begin
    vec_t        vecs[7];
    int unsigned acc0, beats, n_da, n_rd, last;
    logic        busy_at[20];

    vecs[0] = '{32'h0000_0400, 8'd31, 1'b0, 1, 32, 23'h000200, 16'h0200, 1'b0};
    vecs[1] = '{32'h0000_0400, 8'd31, 1'b1, 3, 32, 23'h000200, 16'h0200, 1'b0};
    vecs[2] = '{32'h0000_1235, 8'd3,  1'b0, 2, 4,  23'h00091A, 16'h091A, 1'b0};
    vecs[3] = '{32'h0000_0800, 8'd40, 1'b0, 1, 32, 23'h000400, 16'h0400, 1'b1};
    vecs[4] = '{32'h2000_0000, 8'd0,  1'b0, 1, 1,  23'h000000, 16'h0000, 1'b0};
    vecs[5] = '{32'hFFFF_FFFC, 8'd3,  1'b0, 1, 4,  23'h7FFFFE, 16'hFFFE, 1'b0};
    vecs[6] = '{32'h0000_0010, 8'd32, 1'b1, 2, 32, 23'h000008, 16'h0008, 1'b1};

    reset         = 1'b0;
    bus.rw_req    = 1'b0;
    bus.address   = '0;
    bus.burst_len = '0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_data_available", {31'd0, bus.data_available}, 32'd0);
    check("reset_read_data", 32'(bus.read_data), 32'd0);
    check("reset_err_overlen", {31'd0, bus.err_overlen}, 32'd0);
    check("reset_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    reset = 1'b1;

    for (int t = 0; t < 7; t++) run_burst(vecs[t], -1);

    // Drop rw_req after 5 accepted reads; latency 2 leaves 2 reads outstanding.
    lat    = 2;
    toggle = 1'b0;
    @(negedge clk);
    bus.address   = 32'h0000_0400;
    bus.burst_len = 8'd31;
    bus.rw_req    = 1'b1;
    acc0          = n_acc;
    n_da          = 0;
    for (int i = 0; i < 50 && (n_acc - acc0) < 5; i++) begin
      @(negedge clk);
      #2;
      if (bus.data_available) n_da++;
    end
    @(negedge clk);
    bus.rw_req = 1'b0;
    #2;
    check("abort_mem_rd_same_cycle", {31'd0, bus.mem_rd}, 32'd0);
    beats = bus.mem_rvalid ? 1 : 0;
    last  = 0;
    n_rd  = 0;
    busy_at[0] = bus.busy;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      #2;
      busy_at[i] = bus.busy;
      if (bus.mem_rvalid) begin
        beats++;
        last = i;
      end
      if (bus.mem_rd) n_rd++;
      if (bus.data_available) n_da++;
    end
    check("drain_beats", beats, 2);
    check("drain_mem_rd", n_rd, 0);
    check("drain_reads_issued", n_acc - acc0, 5);
    check("drain_data_available", n_da, 0);
    check("drain_busy_at_last_beat", {31'd0, busy_at[last]}, 32'd1);
    check("drain_idle_after_last_beat", {31'd0, busy_at[last+1]}, 32'd0);
    check("drain_queue_empty", pend.size(), 0);

    // Reset while word 10 of a stream is on read_data.
    run_burst(vecs[0], 10);
    reset = 1'b0;
    @(negedge clk);
    reset      = 1'b1;
    bus.rw_req = 1'b0;
    #2;
    check("midreset_read_data", 32'(bus.read_data), 32'd0);
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_data_available", {31'd0, bus.data_available}, 32'd0);
    check("midreset_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    run_burst(vecs[2], -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/burst_rd_responder.md
BURST_RD_RESPONDER -- requirements
Module: burst_rd_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, the word-address width of the backing memory.
REQ-002 SHALL have parameter MAX_WORDS, default 32, the prefetch buffer depth in 16-bit words (power of two).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset (reset clk).
REQ-005 SHALL have port address, input, 32, the requester byte address, with bit 0 ignored.
REQ-006 SHALL have port rw_req, input, 1, held high by the requester for the whole burst.
REQ-007 SHALL have port burst_len, input, 8, giving words-1 for the burst.
REQ-008 SHALL have port data_available, output, 1, a single-cycle pulse announcing the data stream.
REQ-009 SHALL have port read_data, output, 16, carrying the streamed word.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have port err_overlen, output, 1, a one-cycle pulse when burst_len > MAX_WORDS-1.
REQ-012 SHALL have port mem_addr, output, ADDR_W, the backing-memory word address.
REQ-013 SHALL have port mem_rd, output, 1, the memory read request.
REQ-014 SHALL have port mem_ready, input, 1, where the request is accepted when mem_rd&mem_ready.
REQ-015 SHALL have port mem_rdata, input, 16, the returned memory word.
REQ-016 SHALL have port mem_rvalid, input, 1, where mem_rdata is valid when high, in request order, with latency >=1.

Function
REQ-017 SHALL implement states IDLE, FILL, ANNOUNCE, STREAM, WAIT_RELEASE, DRAIN.
REQ-018 In IDLE with rw_req=1, SHALL capture base=address[ADDR_W:1], set len=min(burst_len,MAX_WORDS-1)+1, clear the issued/received counters, pulse err_overlen if clamped, and go to FILL.
REQ-019 In FILL, SHALL drive mem_rd=1 with mem_addr=base+issued (mod 2^ADDR_W) while issued<len, and increment issued on each mem_rd&mem_ready.
REQ-020 SHALL write each mem_rvalid word to buffer[received] and increment received while received<issued.
REQ-021 SHALL ignore any mem_rvalid beat arriving when received==issued.
REQ-022 SHALL go from FILL to ANNOUNCE in the cycle after received reaches len.
REQ-023 In ANNOUNCE, SHALL assert data_available for exactly one cycle (cycle T), then go to STREAM.
REQ-024 SHALL drive read_data=buffer[k] during cycle T+1+k for k=0..len-1, with no gaps, and drive read_data=0 in all other cycles.
REQ-025 SHALL go from STREAM to WAIT_RELEASE after word len-1.
REQ-026 SHALL stay in WAIT_RELEASE until rw_req=0, then go to IDLE, and SHALL NOT accept a new request in the same cycle.
REQ-027 SHALL, if rw_req=0 in FILL, go to DRAIN immediately and stop issuing mem_rd that cycle.
REQ-028 SHALL, if rw_req=0 in ANNOUNCE or STREAM, abort the stream, drive read_data=0 and data_available=0 from the next cycle, and go to IDLE.
REQ-029 SHALL, in DRAIN, discard mem_rvalid beats until received==issued, then go to IDLE.
REQ-030 SHALL, in DRAIN with no outstanding reads, go to IDLE in the next cycle.
REQ-031 SHALL drive mem_rd=0 in every state except FILL.
REQ-032 SHALL sample burst_len and address only in IDLE, so changes mid-burst have no effect.
REQ-033 SHALL use ceil(log2(MAX_WORDS))+1-bit counters, which SHALL never wrap because len<=MAX_WORDS.

Reset
REQ-034 SHALL, when reset=0 at a clk edge, go to IDLE and clear the issued/received/stream counters.
REQ-035 SHALL, on reset, drive data_available=0, read_data=0, busy=0, err_overlen=0, mem_rd=0, and mem_addr=0 from the next cycle.
REQ-036 SHALL leave buffer contents unreset, and a reset mid-operation SHALL abandon the burst with no drain, ignoring late mem_rvalid beats.

Verification
REQ-037 Bench SHALL cover: address=0x400, burst_len=31, mem_ready=1, 1-cycle latency, mem[i]=i -> mem_addr 0x200..0x21F, one data_available pulse, read_data 0x0200..0x021F on 32 consecutive cycles.
REQ-038 Bench SHALL cover: the same request with mem_ready toggling every cycle and latency 3 -> an identical read_data sequence, with only the data_available pulse delayed.
REQ-039 Bench SHALL cover: burst_len=3, rw_req held 10 cycles after the stream -> 4 words, busy=1 until rw_req=0, then IDLE one cycle later, with a second request served only after that.
REQ-040 Bench SHALL cover: burst_len=40 -> err_overlen pulse in the capture cycle and exactly 32 words streamed.
REQ-041 Bench SHALL cover: rw_req dropped after 5 accepted reads with 2 outstanding -> no further mem_rd, 2 beats discarded, busy=0 after the last beat, and data_available never asserted.
REQ-042 Bench SHALL cover: reset=0 during STREAM at word 10 -> next cycle read_data=0, busy=0, and a new request then returns correct data.
